// File: rtl/grad_accum.sv
// grad_accum: walks a source vector (header word holding N, data following) and
// accumulates it element-wise into an accumulator vector in memory, one request at a time.
// A clear pass overwrites instead of adding and restarts the batch counter.
// Optional feature: define GRAD_ACCUM_SAT_EN to saturate the accumulate add on signed
// overflow; without it the add wraps modulo 2^32.
module grad_accum #(
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        clear,
  input  logic [31:0] src_base,
  input  logic [31:0] acc_base,
  output logic [31:0] mem_addr,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        done,
  output logic        err,
  output logic [15:0] batch_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StHdrRd,
    StSrcRd,
    StAccRd,
    StAccWr,
    StDone
  } state_e;

  state_e      state_q, state_d;

  // Per-pass latches, fixed once the pass starts.
  logic        clear_q, clear_d;
  logic [31:0] src_base_q, src_base_d;
  logic [31:0] acc_base_q, acc_base_d;

  // Datapath registers.
  logic [31:0] n_q, n_d;
  logic [31:0] i_q, i_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;

  // Status and memory request registers.
  logic        err_q, err_d;
  logic [15:0] batch_cnt_q, batch_cnt_d;
  logic        r_en_q, r_en_d;
  logic        w_en_q, w_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        busy;
  logic        pass_ok;

  // Accumulate add: wraps, or clamps to the signed 32-bit range when saturation is built in.
  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sum;
    sum = a + b;
`ifdef GRAD_ACCUM_SAT_EN
    // Overflow only when both operands share a sign that the sum does not.
    if ((a[31] == b[31]) && (sum[31] != a[31])) begin
      sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`endif
    return sum;
  endfunction

  // A request is outstanding while either enable is high; mem_done only counts then.
  assign busy = r_en_q | w_en_q;

  // Next-state, request issue and completion handling.
  always_comb begin
    state_d     = state_q;
    clear_d     = clear_q;
    src_base_d  = src_base_q;
    acc_base_d  = acc_base_q;
    n_d         = n_q;
    i_d         = i_q;
    x_d         = x_q;
    y_d         = y_q;
    err_d       = err_q;
    batch_cnt_d = batch_cnt_q;
    r_en_d      = r_en_q;
    w_en_d      = w_en_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pass_ok     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          clear_d    = clear;
          src_base_d = src_base;
          acc_base_d = acc_base;
          err_d      = 1'b0;
          state_d    = StHdrRd;
        end
      end

      StHdrRd: begin
        if (!busy) begin
          r_en_d = 1'b1;
          addr_d = src_base_q;
        end else if (mem_done) begin
          r_en_d = 1'b0;
          n_d    = mem_rdata;
          i_d    = 32'd0;
          if (mem_rdata == 32'd0) begin
            state_d = StDone;
            pass_ok = 1'b1;
          end else if (mem_rdata > 32'(MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StSrcRd;
          end
        end
      end

      StSrcRd: begin
        if (!busy) begin
          r_en_d = 1'b1;
          addr_d = src_base_q + 32'd1 + i_q;
        end else if (mem_done) begin
          r_en_d  = 1'b0;
          x_d     = mem_rdata;
          // A clear pass never needs the old accumulator value.
          state_d = clear_q ? StAccWr : StAccRd;
        end
      end

      StAccRd: begin
        if (!busy) begin
          r_en_d = 1'b1;
          addr_d = acc_base_q + i_q;
        end else if (mem_done) begin
          r_en_d  = 1'b0;
          y_d     = mem_rdata;
          state_d = StAccWr;
        end
      end

      StAccWr: begin
        if (!busy) begin
          w_en_d  = 1'b1;
          addr_d  = acc_base_q + i_q;
          wdata_d = clear_q ? x_q : acc_add(y_q, x_q);
        end else if (mem_done) begin
          w_en_d = 1'b0;
          i_d    = i_q + 32'd1;
          if (i_q == n_q - 32'd1) begin
            state_d = StDone;
            pass_ok = 1'b1;
          end else begin
            state_d = StSrcRd;
          end
        end
      end

      StDone: begin
        // Holding go here must not start another pass.
        if (!go) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        r_en_d  = 1'b0;
        w_en_d  = 1'b0;
      end
    endcase

    // Batch counter moves only on an error-free DONE entry.
    if (pass_ok) begin
      if (clear_q) begin
        batch_cnt_d = 16'd1;
      end else if (batch_cnt_q != 16'hFFFF) begin
        batch_cnt_d = batch_cnt_q + 16'd1;
      end
    end
  end

  // Control state, status and memory interface registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      err_q       <= 1'b0;
      batch_cnt_q <= 16'd0;
      r_en_q      <= 1'b0;
      w_en_q      <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      batch_cnt_q <= batch_cnt_d;
      r_en_q      <= r_en_d;
      w_en_q      <= w_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Pass latches and datapath registers; their values are don't-care until the next go.
  always_ff @(posedge clk) begin
    clear_q    <= clear_d;
    src_base_q <= src_base_d;
    acc_base_q <= acc_base_d;
    n_q        <= n_d;
    i_q        <= i_d;
    x_q        <= x_d;
    y_q        <= y_d;
  end

  assign mem_addr  = addr_q;
  assign mem_r_en  = r_en_q;
  assign mem_w_en  = w_en_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign batch_cnt = batch_cnt_q;

endmodule

// File: tb/tb_grad_accum.sv
// tb_grad_accum: self-checking bench for grad_accum. A behavioural memory with random
// completion latency serves requests; expected accumulator contents, counts and status
// come from a plain-arithmetic reference model of each pass.
module tb_grad_accum;

  localparam int unsigned MaxLen = 16;
  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  logic        clk;
  logic        rst;
  logic        go;
  logic        clear;
  logic [31:0] src_base;
  logic [31:0] acc_base;
  logic [31:0] mem_addr;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        done;
  logic        err;
  logic [15:0] batch_cnt;

  grad_accum #(.MAX_LEN(MaxLen)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .clear     (clear),
    .src_base  (src_base),
    .acc_base  (acc_base),
    .mem_addr  (mem_addr),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .done      (done),
    .err       (err),
    .batch_cnt (batch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  int total = 0;
  int bad = 0;

  // Request accounting for the current pass.
  int hdr_rd_n, src_rd_n, acc_rd_n, wr_n, stray_fired;
  logic [31:0] cur_sb, cur_ab;
  logic        stall_en;
  logic [31:0] stall_addr;
  logic        stray_arm;
  int          bc_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem[a[11:0]];
  endfunction

  // Reference add on wide signed integers, then clamp or truncate.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef GRAD_ACCUM_SAT_EN
    if (s > SMax) s = SMax;
    else if (s < SMin) s = SMin;
`endif
    return s[31:0];
  endfunction

  // Memory responder: random 0-7 cycle latency, optional stall on one address, one-shot
  // stray pulse when armed and no request is outstanding.
  logic        req_rd;
  logic [31:0] req_addr, req_wdata;
  int          dly, k;
  logic        aborted;
  initial begin : responder
    mem_done  = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_done  = 1'b0;
      mem_rdata = $urandom;
      if (rst) continue;
      if (!mem_r_en && !mem_w_en) begin
        if (stray_arm) begin
          stray_arm   = 1'b0;
          stray_fired = stray_fired + 1;
          mem_done    = 1'b1;
        end
      end else begin
        req_rd    = mem_r_en;
        req_addr  = mem_addr;
        req_wdata = mem_wdata;
        chk("en_exclusive", {31'd0, mem_r_en & mem_w_en}, 32'd0);
        dly     = $urandom_range(0, 7);
        k       = 0;
        aborted = 1'b0;
        while (!aborted && (k < dly || (stall_en && req_rd && req_addr == stall_addr))) begin
          @(posedge clk);
          #1;
          k++;
          if (rst || !(mem_r_en || mem_w_en) || k > 3000) begin
            aborted = 1'b0 | 1'b1;
          end else begin
            chk("stall_addr", mem_addr, req_addr);
            chk("stall_rd", {31'd0, mem_r_en}, {31'd0, req_rd});
            chk("stall_wdata", req_rd ? 32'd0 : mem_wdata, req_rd ? 32'd0 : req_wdata);
          end
        end
        if (!aborted) begin
          if (req_rd) begin
            mem_rdata = mrd(req_addr);
            if (req_addr == cur_sb) hdr_rd_n++;
            else if (req_addr >= cur_ab && req_addr < cur_ab + 32'd64) acc_rd_n++;
            else src_rd_n++;
          end else begin
            chk("wr_addr", req_addr, cur_ab + 32'(wr_n));
            mem[req_addr[11:0]] = req_wdata;
            wr_n++;
          end
          mem_done = 1'b1;
        end
      end
    end
  end

  // One full pass with expectations computed from the memory image before it starts.
  task automatic run_pass(input string tag, input logic clr, input logic [31:0] sb,
                          input logic [31:0] ab, input int extra_go, input logic arm);
    logic [31:0] n;
    logic [31:0] exp_acc [0:63];
    logic        exp_err;
    int          nn, cyc;
    n       = mrd(sb);
    exp_err = (n > MaxLen);
    nn      = exp_err ? 0 : int'(n);
    for (int j = 0; j < nn + 2; j++) begin
      if (j < nn) exp_acc[j] = clr ? mrd(sb + 1 + j) : ref_add(mrd(ab + j), mrd(sb + 1 + j));
      else exp_acc[j] = mrd(ab + j);
    end
    if (!exp_err) bc_model = clr ? 1 : (bc_model == 65535 ? 65535 : bc_model + 1);
    hdr_rd_n = 0; src_rd_n = 0; acc_rd_n = 0; wr_n = 0;
    cur_sb = sb; cur_ab = ab;
    @(negedge clk);
    clear = clr; src_base = sb; acc_base = ab; go = 1'b1;
    if (arm) stray_arm = 1'b1;
    @(negedge clk);
    // Inputs change after the start; the pass must use the latched copies.
    clear = ~clr; src_base = $urandom; acc_base = $urandom;
    cyc = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_batch"}, {16'd0, batch_cnt}, 32'(bc_model));
    chk({tag, "_hdr_rd"}, 32'(hdr_rd_n), 32'd1);
    chk({tag, "_src_rd"}, 32'(src_rd_n), 32'(nn));
    chk({tag, "_acc_rd"}, 32'(acc_rd_n), clr ? 32'd0 : 32'(nn));
    chk({tag, "_writes"}, 32'(wr_n), 32'(nn));
    for (int j = 0; j < nn + 2; j++) begin
      chk($sformatf("%s_acc%0d", tag, j), mrd(ab + j), exp_acc[j]);
    end
    if (extra_go > 0) begin
      repeat (extra_go) @(negedge clk);
      chk({tag, "_hold_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_hold_hdr"}, 32'(hdr_rd_n), 32'd1);
      chk({tag, "_hold_wr"}, 32'(wr_n), 32'(nn));
    end
    go = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_batch"}, {16'd0, batch_cnt}, 32'd0);
    chk({tag, "_r_en"}, {31'd0, mem_r_en}, 32'd0);
    chk({tag, "_w_en"}, {31'd0, mem_w_en}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin : main
    logic [31:0] pre [0:3];
    logic [31:0] n_r;
    int          cyc;
    logic        seen;
    rst = 1'b1; go = 1'b0; clear = 1'b0; src_base = 32'd0; acc_base = 32'd0;
    stall_en = 1'b0; stall_addr = 32'd0; stray_arm = 1'b0; stray_fired = 0;
    cur_sb = 32'hFFFF_FFFF; cur_ab = 32'hFFFF_FFFF; bc_model = 0;
    hdr_rd_n = 0; src_rd_n = 0; acc_rd_n = 0; wr_n = 0;
    for (int a = 0; a < 4096; a++) mem[a] = $urandom;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic accumulate.
    mem[100] = 3; mem[101] = 1; mem[102] = 2; mem[103] = 3;
    mem[1000] = 10; mem[1001] = 20; mem[1002] = 30;
    run_pass("basic", 1'b0, 32'd100, 32'd1000, 0, 1'b0);
    chk("basic_c0", mem[1000], 32'd11);
    chk("basic_c1", mem[1001], 32'd22);
    chk("basic_c2", mem[1002], 32'd33);

    // Clear pass over junk accumulator contents.
    mem[200] = 2; mem[201] = 5; mem[202] = 32'hFFFF_FFFF;
    run_pass("clear", 1'b1, 32'd200, 32'd1000, 0, 1'b0);
    chk("clear_c0", mem[1000], 32'd5);
    chk("clear_c1", mem[1001], 32'hFFFF_FFFF);
    chk("clear_batch1", {16'd0, batch_cnt}, 32'd1);

    // Boundary counts; a stray pulse fires while fully idle before the N=0 pass.
    stray_arm = 1'b1;
    repeat (2) @(negedge clk);
    chk("stray_idle_fired", 32'(stray_fired), 32'd1);
    chk("stray_idle_done", {31'd0, done}, 32'd0);
    mem[300] = 0;
    run_pass("n0", 1'b0, 32'd300, 32'd1100, 0, 1'b0);
    mem[400] = MaxLen + 1;
    run_pass("nbig", 1'b0, 32'd400, 32'd1200, 0, 1'b0);
    mem[500] = MaxLen;
    run_pass("nmax", 1'b0, 32'd500, 32'd1300, 0, 1'b0);

    // Signed overflow on the accumulate add.
    mem[600] = 1; mem[601] = 1; mem[1400] = 32'h7FFF_FFFF;
    run_pass("ovf", 1'b0, 32'd600, 32'd1400, 0, 1'b0);
`ifdef GRAD_ACCUM_SAT_EN
    chk("ovf_const", mem[1400], 32'h7FFF_FFFF);
`else
    chk("ovf_const", mem[1400], 32'h8000_0000);
`endif

    // Random passes; one carries a stray pulse in the gap after go.
    for (int p = 0; p < 4; p++) begin
      n_r = 32'($urandom_range(1, MaxLen));
      mem[2000 + p * 100] = n_r;
      for (int j = 0; j < MaxLen; j++) mem[2001 + p * 100 + j] = $urandom;
      run_pass($sformatf("rnd%0d", p), p == 2, 32'(2000 + p * 100), 32'(3000 + p * 100), 0,
               p == 1);
    end
    chk("stray_gap_fired", 32'(stray_fired), 32'd2);

    // go held high well past done.
    mem[650] = 2; mem[651] = 7; mem[652] = 9;
    run_pass("hold", 1'b0, 32'd650, 32'd1450, 10, 1'b0);

    // Reset while the second accumulator read is stalled.
    mem[700] = 4;
    for (int j = 0; j < 4; j++) pre[j] = mem[1500 + j];
    cur_sb = 32'd700; cur_ab = 32'd1500; wr_n = 0;
    stall_addr = 32'd1501; stall_en = 1'b1;
    @(negedge clk);
    clear = 1'b0; src_base = 32'd700; acc_base = 32'd1500; go = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      seen = mem_r_en && (mem_addr == 32'd1501);
    end
    chk("rst_reached_acc_rd", {31'd0, seen}, 32'd1);
    rst = 1'b1; go = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0; stall_en = 1'b0;
    bc_model = 0;
    repeat (3) @(negedge clk);
    chk("midrst_quiet_r", {31'd0, mem_r_en}, 32'd0);
    chk("midrst_acc0", mem[1500], ref_add(pre[0], mem[701]));
    for (int j = 1; j < 4; j++) chk($sformatf("midrst_acc%0d", j), mem[1500 + j], pre[j]);

    // Recovery pass after reset starts the batch count from zero.
    run_pass("after_rst", 1'b0, 32'd100, 32'd1000, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grad_accum.md
GRAD_ACCUM -- requirements
Module: grad_accum

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1024, meaning the largest legal element count read from the source header.
REQ-002 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-003 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-004 SHALL have port go, input, 1, meaning start one accumulation pass, level-held until done.
REQ-005 SHALL have port clear, input, 1, sampled with go, meaning overwrite rather than add (first sample of a batch).
REQ-006 SHALL have port src_base, input, 32, meaning address of the source header word; the header holds element count N and data follows at src_base+1.
REQ-007 SHALL have port acc_base, input, 32, meaning address of accumulator element 0 (no header).
REQ-008 SHALL have port mem_addr, output, 32, meaning word address of the current memory request.
REQ-009 SHALL have ports mem_r_en and mem_w_en, output, 1 each, meaning read request and write request.
REQ-010 SHALL have port mem_wdata, output, 32, meaning store data.
REQ-011 SHALL have ports mem_rdata (input, 32, load data) and mem_done (input, 1, one-cycle completion pulse).
REQ-012 SHALL have port done, output, 1, meaning the pass is complete.
REQ-013 SHALL have port err, output, 1, meaning N exceeded MAX_LEN on the last pass.
REQ-014 SHALL have port batch_cnt, output, 16, meaning the number of passes completed since the last clear pass.

Function
REQ-015 SHALL implement the states IDLE, HDR_RD, SRC_RD, ACC_RD, ACC_WR and DONE.
REQ-016 SHALL move from IDLE to HDR_RD on go=1, latching clear, src_base and acc_base; the latched values stay fixed for the rest of the pass.
REQ-017 SHALL, in HDR_RD, read src_base, latch N on mem_done and set element index i=0.
  - N=0 -> DONE.
  - N>MAX_LEN -> err=1 and DONE, with no writes.
  - Otherwise -> SRC_RD.
REQ-018 SHALL, in SRC_RD, read src_base+1+i, latch the operand x on mem_done and go to ACC_RD; when the clear latch is set it goes directly to ACC_WR instead.
REQ-019 SHALL, in ACC_RD, read acc_base+i, latch y on mem_done and go to ACC_WR.
REQ-020 SHALL, in ACC_WR, write acc_base+i with y+x (or x when clear is latched); on mem_done it increments i.
  - i==N-1 -> DONE.
  - Otherwise -> SRC_RD.
REQ-021 SHALL follow these memory handshake rules:
  - mem_r_en/mem_w_en are registered, never both high, and held with stable mem_addr/mem_wdata until the mem_done cycle.
  - The enable drops in the cycle after mem_done.
  - The next request is asserted no earlier than the following cycle.
REQ-022 SHALL ignore mem_done arriving while no request is outstanding.
REQ-023 SHALL assert done exactly while in DONE; DONE returns to IDLE on go=0, and go held high in DONE does not restart a pass.
REQ-024 SHALL update batch_cnt on DONE entry after a pass without error:
  - When clear was latched, batch_cnt is set to 1.
  - Otherwise batch_cnt increments, saturating at 16'hFFFF.
  - An N=0 pass counts as without error.
REQ-025 SHALL clear err on the next transition from IDLE to HDR_RD.
REQ-026 SHALL perform all adds as 32-bit two's-complement, with the behaviour selected by REQ-031/REQ-032.

Reset
REQ-027 SHALL, on rst=1 at a clk edge, enter IDLE and drive done=0, err=0, batch_cnt=0, mem_r_en=0, mem_w_en=0, mem_addr=0 and mem_wdata=0.
REQ-028 SHALL let rst take priority over go and mem_done in the same cycle.
REQ-029 SHALL, on rst mid-pass, abandon the outstanding request and leave accumulator contents already written unchanged.
REQ-030 SHALL leave the latched N, i, x and y unspecified after reset, with no observable effect before the next go.

Configuration
REQ-031 SHALL, when macro GRAD_ACCUM_SAT_EN is defined, saturate the accumulate add to 32'h7FFFFFFF / 32'h80000000 on signed overflow.
REQ-032 SHALL, when GRAD_ACCUM_SAT_EN is undefined, let the add wrap modulo 2^32.

Verification
REQ-033 SHALL cover the basic accumulate:
  - Stimulus: header N=3, src={1,2,3}, acc={10,20,30}, clear=0.
  - Response: acc={11,22,33}, 3 write requests, done=1, batch_cnt incremented by 1.
REQ-034 SHALL cover the clear pass:
  - Stimulus: clear=1, src={5,-1}, acc holds junk.
  - Response: acc={5,0xFFFFFFFF}, no acc reads issued, batch_cnt=1.
REQ-035 SHALL cover the boundary counts:
  - N=0 -> DONE with no data requests and err=0.
  - N=MAX_LEN+1 -> err=1, zero writes.
  - The next legal go clears err.
REQ-036 SHALL cover the overflow case:
  - Stimulus: acc=0x7FFFFFFF, src=1.
  - Response: acc=0x7FFFFFFF with GRAD_ACCUM_SAT_EN defined, 0x80000000 without.
REQ-037 SHALL cover a stalled memory and mid-pass reset:
  - Stimulus: mem_done delayed 0-7 random cycles, with one extra stray mem_done pulse while idle between requests.
  - Response: addresses/data stable during each stall, the stray pulse ignored, results unchanged.
  - Stimulus: rst during ACC_RD.
  - Response: IDLE next cycle with all outputs at reset values.
REQ-038 SHALL cover go held high:
  - Stimulus: go held high 10 cycles past done.
  - Response: a single pass only; done stays high until go=0, then IDLE.
